ifid_pipe_stage: RTL and testbench
==================================

// Module: ifid_pipe_stage
// PURPOSE
// - Parametrised IF->ID pipeline register with valid/ready handshake, a 2-entry skid buffer and branch flush.
// - Fetch side pushes {instr, pc_next}. Decode side pops them.
// - Backpressure from decode is absorbed by the skid slot, so in_ready is a registered signal.
// - Flush drops everything in flight. A bubble presents out_instr = NOP_INSTR.
// PARAMETERS
// - INSTR_W    16        instruction width in bits
// - PC_W       16        PC width in bits
// - NOP_INSTR  16'h0800  encoding driven on out_instr whenever out_valid=0; width INSTR_W
// - CNT_W      16        perf-counter width; used only with IFID_PERF_CNT_EN
// PORTS
// - clk          in   1        rising-edge clock
// - rst          in   1        asynchronous, active-low reset
// - flush        in   1        branch/redirect flush; synchronous
// - in_valid     in   1        fetch presents a valid instruction
// - in_ready     out  1        stage can accept; registered
// - in_instr     in   INSTR_W  fetched instruction
// - in_pc_next   in   PC_W     PC+2 of the fetched instruction
// - out_valid    out  1        decode slot holds a valid instruction
// - out_ready    in   1        decode consumes this cycle (0 = stall)
// - out_instr    out  INSTR_W  instruction to decode; NOP_INSTR when out_valid=0
// - out_pc_next  out  PC_W     pc_next of out_instr
// - stall_cnt    out  CNT_W    cycles with out_valid & ~out_ready; IFID_PERF_CNT_EN only
// - flush_cnt    out  CNT_W    flush pulses accepted; IFID_PERF_CNT_EN only
// BEHAVIOUR
// - Reset (rst=0, async):
//   - out_valid=0, out_instr=NOP_INSTR, out_pc_next=0.
//   - Skid slot empty, in_ready=1, counters=0.
// - Handshakes:
//   - Input accepted when in_valid & in_ready.
//   - Output consumed when out_valid & out_ready.
// - Latency: 1 cycle from accept to out_valid when main slot free. Throughput 1/cycle with no stall.
// - Slot states (main,skid): EMPTY(0,0) -> ONE(1,0) -> FULL(1,1).
//   - EMPTY + accept -> ONE.
//   - ONE + accept + consume -> ONE; main is loaded with the new input.
//   - ONE + accept + no consume -> FULL; input goes to skid.
//   - ONE + consume only -> EMPTY.
//   - FULL + consume -> ONE; skid moves to main, skid cleared.
//   - FULL + no consume -> FULL, all held.
// - in_ready = ~skid_valid. FULL never sees an accept.
// - Ordering is strictly FIFO; the skid entry always leaves before any newer input.
// - Flush has top priority over accept and consume in the same cycle.
//   - Next cycle: EMPTY, out_instr=NOP_INSTR, out_pc_next holds its last value, in_ready=1.
//   - The input presented during the flush cycle is dropped.
// - Reset deasserting mid-stream restarts in EMPTY. No partial entry survives.
// - Data registers load only on their enable. Holding the data in a stall is done by the enable, not by feedback muxes.
// CONFIGURATION
// - IFID_PERF_CNT_EN defined:
//   - stall_cnt and flush_cnt are present.
//   - Both saturate at all-ones and do not wrap. Both clear on reset.
// - IFID_PERF_CNT_EN undefined:
//   - Counter ports and logic are absent.
//   - All other behaviour is identical.
// STRUCTURE
// - Package ifid_pkg:
//   - localparams for the default INSTR_W, PC_W, NOP_INSTR.
//   - typedef ifid_payload_t = packed {instr, pc_next}.
//   - enum slot_state_t {EMPTY, ONE, FULL}.
// - One sub-module, ifid_slot: payload register + valid bit.
//   - Async active-low reset; load enable; sync clear; drives NOP_INSTR when invalid.
//   - Instantiated twice (main, skid).
// TESTING
// - Reset: rst=0 with in_valid=1 -> out_valid=0, out_instr=16'h0800, in_ready=1. Still holds after rst=1 with no accept.
// - Streaming: in_valid=1 with instr 0x1001..0x1004, out_ready=1 -> same sequence on out_instr, 1-cycle latency, no gaps.
// - Stall:
//   - out_ready=0 while 0x2001 is in main and 0x2002 arrives -> 0x2002 held in skid; in_ready=0 next cycle.
//   - out_ready=1 again -> 0x2001 then 0x2002 in order.
// - Flush: flush=1 in FULL with in_valid=1 (0x3003) -> next cycle out_valid=0, out_instr=0x0800, in_ready=1. 0x3003 never appears.
// - Flush + consume + accept in the same cycle -> flush wins; EMPTY next cycle.
// - Perf (IFID_PERF_CNT_EN, CNT_W=4):
//   - 20 stall cycles -> stall_cnt=4'hF (saturated).
//   - 3 flushes -> flush_cnt=3.
//   - Rebuild without the macro -> counter ports absent, other tests pass unchanged.

Source files
------------

// File: rtl/ifid_pkg.sv
// Shared types and default widths for the IF->ID pipeline stage.
// Optional perf counters in the top are enabled with IFID_PERF_CNT_EN.
package ifid_pkg;

  localparam int              INSTR_W_DEF   = 16;
  localparam int              PC_W_DEF      = 16;
  localparam int              CNT_W_DEF     = 16;
  localparam logic [15:0]     NOP_INSTR_DEF = 16'h0800;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc_next;
  } ifid_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slot_state_t;

  // A populated skid slot always means both slots are occupied.
  function automatic slot_state_t slot_state_f(input logic main_v, input logic skid_v);
    if (skid_v)
      return FULL;
    else if (main_v)
      return ONE;
    else
      return EMPTY;
  endfunction

endpackage

// File: rtl/ifid_slot.sv
// One payload slot of the IF->ID stage: data register with load enable plus a valid bit.
// An empty slot presents NOP_INSTR; pc_next keeps its last loaded value.
module ifid_slot
  import ifid_pkg::*;
#(
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter int                 PC_W      = PC_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC_W-1:0]    d_pc_next,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc_next
);

  logic               valid_reg;
  logic [INSTR_W-1:0] instr_reg;
  logic [PC_W-1:0]    pc_next_reg;

  // Clear wins over load so a flush can never leave a partially written entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      valid_reg <= 1'b0;
    else if (clear)
      valid_reg <= 1'b0;
    else if (load)
      valid_reg <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_reg   <= '0;
      pc_next_reg <= '0;
    end else if (load && !clear) begin
      instr_reg   <= d_instr;
      pc_next_reg <= d_pc_next;
    end
  end

  assign valid   = valid_reg;
  assign instr   = valid_reg ? instr_reg : NOP_INSTR;
  assign pc_next = pc_next_reg;

endmodule

// File: rtl/ifid_pipe_stage.sv
// IF->ID pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Define IFID_PERF_CNT_EN to add saturating stall_cnt / flush_cnt outputs.
module ifid_pipe_stage
  import ifid_pkg::*;
#(
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter int                 PC_W      = PC_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
`ifdef IFID_PERF_CNT_EN
  ,
  parameter int                 CNT_W     = CNT_W_DEF
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc_next,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc_next
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  localparam int MAIN = 0;
  localparam int SKID = 1;

  logic [1:0]         slot_load;
  logic [1:0]         slot_clear;
  logic [1:0]         slot_valid;
  logic [INSTR_W-1:0] slot_d_instr [2];
  logic [PC_W-1:0]    slot_d_pc    [2];
  logic [INSTR_W-1:0] slot_instr   [2];
  logic [PC_W-1:0]    slot_pc      [2];

  slot_state_t slot_state;
  logic        accept;
  logic        consume;
  logic        main_sel_skid;

  assign slot_state = slot_state_f(slot_valid[MAIN], slot_valid[SKID]);
  assign in_ready   = ~slot_valid[SKID];
  assign accept     = in_valid & in_ready;
  assign consume    = slot_valid[MAIN] & out_ready;

  always_comb begin
    slot_load     = 2'b00;
    slot_clear    = {flush, flush};
    main_sel_skid = 1'b0;
    case (slot_state)
      EMPTY: begin
        if (accept)
          slot_load[MAIN] = 1'b1;
      end
      ONE: begin
        if (accept && consume)
          slot_load[MAIN] = 1'b1;
        else if (accept)
          slot_load[SKID] = 1'b1;
        else if (consume)
          slot_clear[MAIN] = 1'b1;
      end
      FULL: begin
        // Older skid entry advances; in_ready is low so nothing new arrives.
        if (consume) begin
          slot_load[MAIN]  = 1'b1;
          main_sel_skid    = 1'b1;
          slot_clear[SKID] = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign slot_d_instr[MAIN] = main_sel_skid ? slot_instr[SKID] : in_instr;
  assign slot_d_pc[MAIN]    = main_sel_skid ? slot_pc[SKID]    : in_pc_next;
  assign slot_d_instr[SKID] = in_instr;
  assign slot_d_pc[SKID]    = in_pc_next;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    ifid_slot #(
      .INSTR_W   (INSTR_W),
      .PC_W      (PC_W),
      .NOP_INSTR (NOP_INSTR)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load[gi]),
      .clear     (slot_clear[gi]),
      .d_instr   (slot_d_instr[gi]),
      .d_pc_next (slot_d_pc[gi]),
      .valid     (slot_valid[gi]),
      .instr     (slot_instr[gi]),
      .pc_next   (slot_pc[gi])
    );
  end

  assign out_valid   = slot_valid[MAIN];
  assign out_instr   = slot_instr[MAIN];
  assign out_pc_next = slot_pc[MAIN];

`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt_reg <= '0;
    else if (slot_valid[MAIN] && !out_ready && !(&stall_cnt_reg))
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flush_cnt_reg <= '0;
    else if (flush && !(&flush_cnt_reg))
      flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_ifid_pipe_stage.sv
// Self-checking bench for ifid_pipe_stage: scoreboard of accepted entries plus directed scenarios.
// Perf-counter scenario runs only when IFID_PERF_CNT_EN is defined.
module tb_ifid_pipe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = 16'h0;
  logic [15:0] in_pc_next = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_instr;
  logic [15:0] out_pc_next;
`ifdef IFID_PERF_CNT_EN
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  ifid_pipe_stage #(
    .INSTR_W   (16),
    .PC_W      (16),
    .NOP_INSTR (16'h0800)
`ifdef IFID_PERF_CNT_EN
    ,
    .CNT_W     (4)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc_next  (in_pc_next),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc_next (out_pc_next)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  // Scoreboard: push on accept, pop and compare on consume; flush/reset empty it.
  always @(posedge clk) begin
    logic [31:0] exp_v;
    if (!rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: got %h/%h, required no output", out_instr, out_pc_next);
        end else begin
          exp_v = sb_q.pop_front();
          if ({out_instr, out_pc_next} !== exp_v) begin
            errors++;
            $display("FAIL sb_data: got %h/%h, required %h/%h",
                     out_instr, out_pc_next, exp_v[31:16], exp_v[15:0]);
          end else begin
            $display("txn out instr=%h pc_next=%h", out_instr, out_pc_next);
          end
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back({in_instr, in_pc_next});
    end
  end

  always @(negedge clk) begin
    if (rst && !out_valid) begin
      checks++;
      if (out_instr !== 16'h0800) begin
        errors++;
        $display("FAIL bubble_nop: got %h, required 0800", out_instr);
      end
    end
  end

  task automatic set_in(input logic v, input logic [15:0] instr);
    in_valid   = v;
    in_instr   = instr;
    in_pc_next = instr + 16'h0002;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    out_ready = 1'b1;
    set_in(1'b1, 16'h0bad);
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 16'h0800 || in_ready !== 1'b1 || out_pc_next !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got v=%b i=%h r=%b pc=%h, required v=0 i=0800 r=1 pc=0000",
               out_valid, out_instr, in_ready, out_pc_next);
    end
    set_in(1'b0, 16'h0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got v=%b r=%b, required v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 16'(16'h1001 + i));
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_instr !== 16'(16'h1001 + i)) begin
        errors++;
        $display("FAIL stream_%0d: got v=%b i=%h, required v=1 i=%h",
                 i, out_valid, out_instr, 16'(16'h1001 + i));
      end
    end
    set_in(1'b0, 16'h0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: got v=%b, required 0", out_valid);
    end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    set_in(1'b1, 16'h2001);
    @(negedge clk);
    checks++;
    if (out_instr !== 16'h2001 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_one: got i=%h r=%b, required i=2001 r=1", out_instr, in_ready);
    end
    set_in(1'b1, 16'h2002);
    @(negedge clk);
    checks++;
    if (out_instr !== 16'h2001 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_full: got i=%h r=%b, required i=2001 r=0", out_instr, in_ready);
    end
    set_in(1'b0, 16'h0);
    @(negedge clk);
    checks++;
    if (out_instr !== 16'h2001 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: got i=%h r=%b, required i=2001 r=0", out_instr, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 16'h2002 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got v=%b i=%h r=%b, required v=1 i=2002 r=1",
               out_valid, out_instr, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: got v=%b, required 0", out_valid);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    set_in(1'b1, 16'h3001);
    @(negedge clk);
    set_in(1'b1, 16'h3002);
    @(negedge clk);
    set_in(1'b1, 16'h3003);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    set_in(1'b0, 16'h0);
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 16'h0800 || in_ready !== 1'b1 || out_pc_next !== 16'h3003) begin
      errors++;
      $display("FAIL flush_full: got v=%b i=%h r=%b pc=%h, required v=0 i=0800 r=1 pc=3003",
               out_valid, out_instr, in_ready, out_pc_next);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_replay: got v=%b i=%h, required v=0", out_valid, out_instr);
    end
  endtask

  task automatic test_flush_priority;
    out_ready = 1'b1;
    set_in(1'b1, 16'h4001);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_instr !== 16'h4001) begin
      errors++;
      $display("FAIL flushpri_load: got v=%b i=%h, required v=1 i=4001", out_valid, out_instr);
    end
    set_in(1'b1, 16'h4002);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    set_in(1'b0, 16'h0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc_next !== 16'h4003) begin
      errors++;
      $display("FAIL flushpri_empty: got v=%b r=%b pc=%h, required v=0 r=1 pc=4003",
               out_valid, in_ready, out_pc_next);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flushpri_drop: got v=%b i=%h, required v=0", out_valid, out_instr);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 60; k++) begin
      set_in(1'($urandom_range(0, 3) != 0), 16'(16'h5000 + k));
      out_ready = 1'($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    set_in(1'b0, 16'h0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got pending=%0d v=%b, required pending=0 v=0", sb_q.size(), out_valid);
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    set_in(1'b1, 16'h6001);
    @(negedge clk);
    set_in(1'b1, 16'h6002);
    @(negedge clk);
    set_in(1'b0, 16'h0);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 16'h0800) begin
      errors++;
      $display("FAIL async_reset: got v=%b r=%b i=%h, required v=0 r=1 i=0800",
               out_valid, in_ready, out_instr);
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_restart: got v=%b, required 0", out_valid);
    end
  endtask

`ifdef IFID_PERF_CNT_EN
  task automatic test_perf;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'h0 || flush_cnt !== 4'h0) begin
      errors++;
      $display("FAIL perf_reset: got s=%h f=%h, required 0/0", stall_cnt, flush_cnt);
    end
    rst = 1'b1;
    out_ready = 1'b0;
    set_in(1'b1, 16'h7001);
    @(negedge clk);
    set_in(1'b0, 16'h0);
    repeat (5) @(negedge clk);
    checks++;
    if (stall_cnt !== 4'h5) begin
      errors++;
      $display("FAIL perf_stall5: got %h, required 5", stall_cnt);
    end
    repeat (15) @(negedge clk);
    checks++;
    if (stall_cnt !== 4'hF) begin
      errors++;
      $display("FAIL perf_stall_sat: got %h, required F", stall_cnt);
    end
    for (int n = 0; n < 3; n++) begin
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (flush_cnt !== 4'h3 || stall_cnt !== 4'hF) begin
      errors++;
      $display("FAIL perf_flush: got f=%h s=%h, required f=3 s=F", flush_cnt, stall_cnt);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_priority();
    test_back_to_back();
    test_async_reset();
`ifdef IFID_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
